// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 responder (MSB first, 8-bit frames), every flop on clk.
// Latency: a pin edge first sampled at clk edge N is acted on at edge N+2.
// Backpressure: unread rx byte drops new bytes (overrun); empty tx holding sends FILL (underrun).
// Optional feature macro: SPI_SLAVE_ERR_FLAGS_EN enables the sticky overrun/underrun flags.
module spi_slave #(
  parameter logic [7:0] FILL = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       overrun,
  output logic       underrun,
  input  logic       err_clr
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t     state_q;
  state_t     state_d;

  logic [1:0] sck_sync;
  logic [1:0] cs_sync;
  logic [1:0] mosi_sync;
  logic       sck_hist;
  logic       cs_hist;
  logic       mosi_hist;

  logic       sck_rise;
  logic       sck_fall;
  logic       cs_rise;
  logic       cs_fall;

  logic       frame_start;
  logic       frame_end;
  logic       bit_sample;
  logic       bit_drive;

  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] tx_shift;
  logic [7:0] rx_byte;
  logic       byte_done;
  logic       rx_accept;

  logic       hold_full;
  logic [7:0] hold_dat;
  logic       tx_accept;
  logic       load_evt;
  logic [7:0] load_byte;

  logic       overrun_set;
  logic       underrun_set;

  // Two-flop synchronizer plus one history flop per SPI pin. Chip select
  // resets to "active" so a cs_n held low across reset never looks like a
  // fresh falling edge; the frame only restarts after cs_n goes high and low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_sync  <= 2'b00;
      cs_sync   <= 2'b00;
      mosi_sync <= 2'b00;
      sck_hist  <= 1'b0;
      cs_hist   <= 1'b0;
      mosi_hist <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[0], spi_sck};
      cs_sync   <= {cs_sync[0], spi_cs_n};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      sck_hist  <= sck_sync[1];
      cs_hist   <= cs_sync[1];
      mosi_hist <= mosi_sync[1];
    end
  end

  assign sck_rise = sck_sync[1] & ~sck_hist;
  assign sck_fall = ~sck_sync[1] & sck_hist;
  assign cs_rise  = cs_sync[1] & ~cs_hist;
  assign cs_fall  = ~cs_sync[1] & cs_hist;

  // Frame state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame sequencing: a cs_n rise ends the frame and wins over any sck edge
  // seen in the same cycle, so a host that drops sck together with cs_n does
  // not trigger a transmit reload after the last byte.
  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    bit_sample  = 1'b0;
    bit_drive   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d     = ST_ACTIVE;
          frame_start = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (cs_rise) begin
          state_d   = ST_IDLE;
          frame_end = 1'b1;
        end else begin
          bit_sample = sck_rise;
          bit_drive  = sck_fall;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q == ST_ACTIVE);

  // A transmit load happens at frame start and at every byte boundary fall.
  assign load_evt     = frame_start | (bit_drive & (bit_cnt == 3'd0));
  assign load_byte    = hold_full ? hold_dat : FILL;
  assign underrun_set = load_evt & ~hold_full;

  assign rx_byte      = {rx_shift, mosi_sync[1]};
  assign byte_done    = bit_sample & (bit_cnt == 3'd7);
  assign rx_accept    = byte_done & (~rx_valid | rx_ready);
  assign overrun_set  = byte_done & ~rx_accept;

  // Bit counter and both shift registers; miso is the transmit register MSB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt  <= 3'd0;
      rx_shift <= 7'd0;
      tx_shift <= 8'd0;
    end else if (frame_start) begin
      bit_cnt  <= 3'd0;
      rx_shift <= 7'd0;
      tx_shift <= load_byte;
    end else if (frame_end) begin
      bit_cnt  <= 3'd0;
      rx_shift <= 7'd0;
      tx_shift <= 8'd0;
    end else begin
      if (bit_sample) begin
        rx_shift <= {rx_shift[5:0], mosi_sync[1]};
        bit_cnt  <= bit_cnt + 3'd1;
      end
      if (bit_drive) begin
        if (bit_cnt == 3'd0) begin
          tx_shift <= load_byte;
        end else begin
          tx_shift <= {tx_shift[6:0], 1'b0};
        end
      end
    end
  end

  assign spi_miso = tx_shift[7];

  // One-entry transmit holding register. An offer can only land while it is
  // empty, so a same-cycle load reads FILL and the offered byte waits for the
  // next load; when full, the load takes the old byte and the offer waits.
  assign tx_accept = tx_valid & ~hold_full;
  assign tx_ready  = ~hold_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_full <= 1'b0;
      hold_dat  <= 8'd0;
    end else if (tx_accept) begin
      hold_full <= 1'b1;
      hold_dat  <= tx_data;
    end else if (load_evt) begin
      hold_full <= 1'b0;
    end
  end

  // Received byte register; a completing byte overrides the pending handshake drop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
    end else if (rx_accept) begin
      rx_data  <= rx_byte;
      rx_valid <= 1'b1;
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

`ifdef SPI_SLAVE_ERR_FLAGS_EN
  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      overrun  <= (overrun & ~err_clr) | overrun_set;
      underrun <= (underrun & ~err_clr) | underrun_set;
    end
  end
`else
  assign overrun  = 1'b0;
  assign underrun = 1'b0;

  logic unused_err;
  assign unused_err = ^{err_clr, overrun_set, underrun_set};
`endif

  // The mosi history flop keeps the three pin paths identical; nothing edge-detects mosi.
  logic unused_mosi_hist;
  assign unused_mosi_hist = mosi_hist;

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed plus randomized frames against a byte-level reference model.
// Host side drives mode-0 SPI with 6-clk sck phases; stimulus changes 2 time units after posedge.
// Model tracks the holding register, the rx register and the sticky flags per byte.
module tb_spi_slave;

  localparam logic [7:0] FILL = 8'hFF;
`ifdef SPI_SLAVE_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       spi_sck;
  logic       spi_cs_n;
  logic       spi_mosi;
  logic       spi_miso;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       overrun;
  logic       underrun;
  logic       err_clr;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  // reference model state
  bit         m_full;
  logic [7:0] m_dat;
  bit         m_und;
  bit         m_ovr;
  bit         m_rxv;
  logic [7:0] m_rxd;

  // per-frame stimulus tables
  logic [7:0] f_mo   [8];
  int         f_offb [8];
  logic [7:0] f_offv [8];

  spi_slave #(.FILL(FILL)) dut (
    .clk      (clk),
    .reset    (reset),
    .spi_sck  (spi_sck),
    .spi_cs_n (spi_cs_n),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .overrun  (overrun),
    .underrun (underrun),
    .err_clr  (err_clr)
  );

  always #5 clk = ~clk;

  // every rx handshake that the next rising edge will complete
  always @(negedge clk) begin
    if (!reset && rx_valid && rx_ready) got_q.push_back(rx_data);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_full = 0; m_dat = 8'h00; m_und = 0; m_ovr = 0; m_rxv = 0; m_rxd = 8'h00;
    got_q.delete(); exp_q.delete();
  endtask

  task automatic m_load(output logic [7:0] b);
    if (m_full) b = m_dat;
    else begin
      b = FILL;
      m_und = 1;
    end
    m_full = 0;
  endtask

  task automatic m_complete(input logic [7:0] b, input bit clr, input bit rdy);
    bit new_ovr;
    new_ovr = 0;
    if (!m_rxv) begin
      m_rxd = b; m_rxv = 1;
    end else if (rdy) begin
      exp_q.push_back(m_rxd); m_rxd = b;
    end else begin
      new_ovr = 1;
    end
    if (clr) begin m_ovr = 0; m_und = 0; end
    if (new_ovr) m_ovr = 1;
    if (rx_ready && m_rxv) begin exp_q.push_back(m_rxd); m_rxv = 0; end
  endtask

  task automatic offer(input logic [7:0] v);
    bit r;
    int guard;
    guard = 0;
    tx_valid = 1'b1;
    tx_data  = v;
    do begin
      r = tx_ready;
      tick(1);
      guard++;
    end while (!r && guard < 20);
    tx_valid = 1'b0;
    chk("tx_offer_accepted", 32'(r), 32'(1));
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1; tick(1); err_clr = 1'b0; tick(1);
    m_ovr = 0; m_und = 0;
  endtask

  // nbits MSB-first bits; pulse 1 = err_clr, 2 = rx_ready, in the byte-complete cycle
  task automatic xfer_byte(input logic [7:0] mo, input int nbits, input int offb,
                           input logic [7:0] offv, input int pulse, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_sck  = 1'b0;
      spi_mosi = mo[i];
      tick(2);
      if ((7 - i) == offb) offer(offv);
      tick(4);
      mi[i]   = spi_miso;
      spi_sck = 1'b1;
      if (i == 0 && pulse != 0) begin
        tick(2);
        if (pulse == 1) err_clr = 1'b1; else rx_ready = 1'b1;
        tick(1);
        err_clr = 1'b0;
        if (pulse == 2) rx_ready = 1'b0;
        tick(3);
      end else begin
        tick(6);
      end
    end
  endtask

  task automatic frame_end();
    spi_sck  = 1'b0;
    spi_cs_n = 1'b1;
    tick(6);
  endtask

  task automatic run_frame(input int nb, input int pulse_last);
    logic [7:0] mi;
    logic [7:0] exp_b;
    int pl;
    spi_cs_n = 1'b0;
    for (int k = 0; k < nb; k++) begin
      pl = (k == nb - 1) ? pulse_last : 0;
      m_load(exp_b);
      if (f_offb[k] >= 0) begin m_full = 1; m_dat = f_offv[k]; end
      xfer_byte(f_mo[k], 8, f_offb[k], f_offv[k], pl, mi);
      chk($sformatf("miso_byte%0d", k), 32'(mi), 32'(exp_b));
      if (k == 0) chk("busy_in_frame", 32'(busy), 32'(1));
      m_complete(f_mo[k], pl == 1, pl == 2);
    end
    frame_end();
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".rx_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({tag, ".rx_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
    chk({tag, ".rx_valid"}, 32'(rx_valid), 32'(m_rxv));
    if (m_rxv) chk({tag, ".rx_data"}, 32'(rx_data), 32'(m_rxd));
    chk({tag, ".tx_ready"}, 32'(tx_ready), 32'(!m_full));
    chk({tag, ".overrun"}, 32'(overrun), 32'(ERR_EN & m_ovr));
    chk({tag, ".underrun"}, 32'(underrun), 32'(ERR_EN & m_und));
    chk({tag, ".busy"}, 32'(busy), 32'(0));
    chk({tag, ".miso"}, 32'(spi_miso), 32'(0));
    got_q.delete(); exp_q.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".miso"}, 32'(spi_miso), 32'(0));
    chk({tag, ".rx_data"}, 32'(rx_data), 32'(8'h00));
    chk({tag, ".rx_valid"}, 32'(rx_valid), 32'(0));
    chk({tag, ".tx_ready"}, 32'(tx_ready), 32'(1));
    chk({tag, ".busy"}, 32'(busy), 32'(0));
    chk({tag, ".overrun"}, 32'(overrun), 32'(0));
    chk({tag, ".underrun"}, 32'(underrun), 32'(0));
  endtask

  task automatic clear_tables();
    for (int k = 0; k < 8; k++) begin
      f_mo[k] = 8'h00; f_offb[k] = -1; f_offv[k] = 8'h00;
    end
  endtask

  initial begin
    logic [7:0] mi;
    logic [7:0] dummy;
    int nb;

    reset = 1'b1; spi_sck = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    rx_ready = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; err_clr = 1'b0;
    m_reset();
    clear_tables();
    tick(3);
    chk_reset_vals("reset");
    reset = 1'b0;
    tick(3);

    // loopback: A5 out, 3C in
    rx_ready = 1'b1;
    offer(8'hA5); m_full = 1; m_dat = 8'hA5;
    clear_tables(); f_mo[0] = 8'h3C;
    run_frame(1, 0);
    check_state("loopback");

    // underrun: only 5A loaded for a 2-byte frame
    offer(8'h5A); m_full = 1; m_dat = 8'h5A;
    clear_tables(); f_mo[0] = 8'h11; f_mo[1] = 8'h22;
    run_frame(2, 0);
    check_state("underrun");
    pulse_err_clr();
    check_state("underrun_clr");

    // sck edges with cs inactive must not consume the held byte or receive
    offer(8'h96); m_full = 1; m_dat = 8'h96;
    for (int i = 0; i < 8; i++) begin
      spi_mosi = 1'b1; spi_sck = 1'b1; tick(6); spi_sck = 1'b0; tick(6);
    end
    check_state("idle_edges");

    // overrun; err_clr coincides with a further overrun in the last byte
    rx_ready = 1'b0;
    clear_tables(); f_mo[0] = 8'h01; f_mo[1] = 8'h02; f_mo[2] = 8'h03;
    run_frame(3, 1);
    check_state("overrun");
    pulse_err_clr();
    check_state("overrun_clr");
    rx_ready = 1'b1; tick(2);
    exp_q.push_back(m_rxd); m_rxv = 0;
    check_state("overrun_drain");

    // byte completes in the same cycle as rx_ready with an unread byte
    rx_ready = 1'b0;
    clear_tables(); f_mo[0] = 8'h44; f_mo[1] = 8'h55;
    run_frame(2, 2);
    check_state("rx_simul");
    rx_ready = 1'b1; tick(2);
    exp_q.push_back(m_rxd); m_rxv = 0;
    check_state("rx_simul_drain");
    pulse_err_clr();

    // offers coinciding with loads: full (old wins) then empty (FILL, then new)
    offer(8'h3A); m_full = 1; m_dat = 8'h3A;
    clear_tables();
    f_mo[0] = 8'h10; f_mo[1] = 8'h20; f_mo[2] = 8'h30; f_mo[3] = 8'h40;
    f_offb[0] = 0; f_offv[0] = 8'hC7;
    f_offb[2] = 0; f_offv[2] = 8'h6B;
    run_frame(4, 0);
    check_state("tx_simul");
    pulse_err_clr();

    // abort after 5 bits of FF
    spi_cs_n = 1'b0;
    m_load(dummy);
    xfer_byte(8'hFF, 5, -1, 8'h00, 0, mi);
    chk("abort_miso_bits", 32'(mi[7:3]), 32'(dummy[7:3]));
    frame_end();
    check_state("abort");
    clear_tables(); f_mo[0] = 8'h81;
    run_frame(1, 0);
    check_state("after_abort");

    // reset in the middle of a byte
    offer(8'hE1); m_full = 1; m_dat = 8'hE1;
    spi_cs_n = 1'b0;
    xfer_byte(8'hC3, 4, -1, 8'h00, 0, mi);
    reset = 1'b1;
    #1;
    chk_reset_vals("reset_mid");
    spi_sck = 1'b0; spi_cs_n = 1'b1;
    tick(2);
    reset = 1'b0;
    m_reset();
    tick(3);
    clear_tables(); f_mo[0] = 8'hC3;
    run_frame(1, 0);
    check_state("after_reset");
    chk("after_reset.rx_data", 32'(rx_data), 32'(8'hC3));

    // randomized frames
    for (int f = 0; f < 8; f++) begin
      if (int'($urandom_range(0, 3)) == 0) pulse_err_clr();
      if (!m_full && $urandom_range(0, 1) == 1) begin
        dummy = 8'($urandom);
        offer(dummy); m_full = 1; m_dat = dummy;
      end
      clear_tables();
      nb = int'($urandom_range(1, 3));
      for (int k = 0; k < nb; k++) begin
        f_mo[k]   = 8'($urandom);
        f_offv[k] = 8'($urandom);
        f_offb[k] = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 7));
      end
      run_frame(nb, 0);
      check_state($sformatf("rand%0d", f));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
